// File: rtl/latch_seq_pkg.sv
// Shared definitions for the SR-latch write sequencer: FSM encoding,
// default timing parameters and a timer sizing helper.
package latch_seq_pkg;

  localparam int DEFAULT_NUM_LATCHES   = 4;
  localparam int DEFAULT_PULSE_CYCLES  = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One timer serves both phases, so it must hold the larger reload value.
  function automatic int timer_width(input int pulse, input int settle);
    int w;
    w = $clog2(max_int(pulse, settle) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; times the pulse and settle phases.
module cycle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Writes one bit into a bank of SR latches with a timed set/reset pulse,
// a quiet settle gap, and a read-back check of the latch output.
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int NUM_LATCHES   = DEFAULT_NUM_LATCHES,
  parameter int PULSE_CYCLES  = DEFAULT_PULSE_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(NUM_LATCHES)-1:0] req_idx,
  input  logic                           req_val,
  input  logic [NUM_LATCHES-1:0]         q_i,
  output logic [NUM_LATCHES-1:0]         set_o,
  output logic [NUM_LATCHES-1:0]         reset_o,
  output logic                           done,
  output logic                           err
);

  localparam int IDX_W = $clog2(NUM_LATCHES);
  localparam int TW    = timer_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  seq_state_t             state;
  logic [IDX_W-1:0]       idx_r;
  logic                   val_r;
  logic                   accept;
  logic                   idx_bad;
  logic                   already_set;
  logic [NUM_LATCHES-1:0] target;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_load_val;
  logic                   tmr_dec;
  logic                   tmr_zero;

  // Request decode and timer control; the timer reloads on entry to each phase.
  always_comb begin
    accept       = (state == ST_IDLE) && req_valid;
    idx_bad      = ({1'b0, req_idx} >= (IDX_W + 1)'(NUM_LATCHES));
    already_set  = !idx_bad && (q_i[req_idx] == req_val);
    target       = NUM_LATCHES'(1) << req_idx;
    tmr_load     = 1'b0;
    tmr_load_val = PULSE_LOAD;
    tmr_dec      = 1'b0;
    if (accept && !idx_bad && !already_set) begin
      tmr_load     = 1'b1;
      tmr_load_val = PULSE_LOAD;
    end else if ((state == ST_PULSE) && tmr_zero) begin
      tmr_load     = 1'b1;
      tmr_load_val = SETTLE_LOAD;
    end else if ((state == ST_PULSE) || (state == ST_SETTLE)) begin
      tmr_dec = 1'b1;
    end
  end

  cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // done/err are set on the edge entering CHECK so they are visible for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_r     <= '0;
      val_r     <= 1'b0;
      set_o     <= '0;
      reset_o   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_r     <= req_idx;
            val_r     <= req_val;
            req_ready <= 1'b0;
            if (idx_bad) begin
              state <= ST_CHECK;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (already_set) begin
              state <= ST_CHECK;
              done  <= 1'b1;
            end else begin
              state   <= ST_PULSE;
              set_o   <= req_val ? target : '0;
              reset_o <= req_val ? '0 : target;
            end
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            state   <= ST_SETTLE;
            set_o   <= '0;
            reset_o <= '0;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state <= ST_CHECK;
            done  <= 1'b1;
            err   <= (q_i[idx_r] != val_r);
          end
        end
        ST_CHECK: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          set_o     <= '0;
          reset_o   <= '0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: a behavioural NOR-latch bank closes the
// feedback loop, and a scoreboard predicts drive windows, done timing and err.
module tb_latch_write_sequencer;

  localparam int N = 4;
  localparam int P = 2;
  localparam int S = 1;

  typedef struct {
    logic [1:0] idx;
    logic       val;
    logic       stuck;
    logic       expSkip;
    logic       expErr;
    logic [3:0] expSet;
    logic [3:0] expReset;
    logic [3:0] expQ;
  } vec_t;

  typedef struct {
    int         acceptEdge;
    int         doneEdge;
    logic       expErr;
    logic [3:0] expSet;
    logic [3:0] expReset;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_idx;
  logic       req_val;
  logic [3:0] qFeedback;
  logic [3:0] set_o;
  logic [3:0] reset_o;
  logic       done;
  logic       err;

  logic [3:0] latchQ = 4'b0000;
  logic [3:0] stuckMask;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         nextAcceptEdge = 0;
  sb_t        sb[$];
  vec_t       vecs[8];

  latch_write_sequencer #(
    .NUM_LATCHES  (N),
    .PULSE_CYCLES (P),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_idx  (req_idx),
    .req_val  (req_val),
    .q_i      (qFeedback),
    .set_o    (set_o),
    .reset_o  (reset_o),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // NOR latch cells: set or reset alone moves Q, both low holds it.
  always @(set_o or reset_o) begin
    for (int i = 0; i < N; i++) begin
      if (set_o[i] && !reset_o[i]) latchQ[i] = 1'b1;
      else if (reset_o[i] && !set_o[i]) latchQ[i] = 1'b0;
    end
  end

  assign qFeedback = latchQ | stuckMask;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Per-cycle monitor: drive windows, drive invariants, done timing and err.
  always @(negedge clk) begin : monitor
    sb_t        head;
    logic [3:0] es;
    logic [3:0] er;
    es = '0;
    er = '0;
    head = '{0, 0, 1'b0, 4'b0, 4'b0};
    if (sb.size() > 0) begin
      head = sb[0];
      if ((cyc >= head.acceptEdge) && (cyc <= head.acceptEdge + P - 1)) begin
        es = head.expSet;
        er = head.expReset;
      end
    end
    checkOutput("setDrive", {28'b0, set_o}, {28'b0, es});
    checkOutput("resetDrive", {28'b0, reset_o}, {28'b0, er});
    checkOutput("noOverlap", {28'b0, set_o & reset_o}, 32'd0);
    checkOutput("atMostOneDrive", {31'b0, $countones(set_o | reset_o) <= 1}, 32'd1);
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", {31'b0, done}, 32'd0);
      end else begin
        checkOutput("doneCycle", cyc, head.doneEdge);
        checkOutput("doneErr", {31'b0, err}, {31'b0, head.expErr});
        void'(sb.pop_front());
      end
    end else if ((sb.size() > 0) && (cyc >= head.doneEdge)) begin
      checkOutput("doneMissing", {31'b0, done}, 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic applyStimulus(input logic [1:0] idx, input logic val, input logic expSkip,
                               input logic expErr, input logic [3:0] expSet, input logic [3:0] expReset);
    sb_t e;
    int  acc;
    acc = (cyc + 1 > nextAcceptEdge) ? cyc + 1 : nextAcceptEdge;
    req_valid = 1'b1;
    req_idx   = idx;
    req_val   = val;
    e.acceptEdge = acc;
    e.doneEdge   = acc + (expSkip ? 0 : P + S);
    e.expErr     = expErr;
    e.expSet     = expSet;
    e.expReset   = expReset;
    sb.push_back(e);
    nextAcceptEdge = e.doneEdge + 2;
    while (cyc < acc - 1) begin
      @(negedge clk); #1;
    end
    checkOutput("readyBeforeAccept", {31'b0, req_ready}, 32'd1);
    @(negedge clk); #1;
    checkOutput("readyAfterAccept", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int k = 0; (k < 40) && (sb.size() != 0); k++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleTimeout: %0d requests outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           idx   val   stuck skip  err   set      reset    q after
    vecs[0] = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100};
    vecs[1] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0100};
    vecs[2] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0100};
    vecs[3] = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001};
    vecs[5] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b1001};
    vecs[6] = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1001};
    vecs[7] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b1000};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_idx   = 2'd0;
    req_val   = 1'b0;
    stuckMask = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstSet", {28'b0, set_o}, 32'd0);
    checkOutput("rstReset", {28'b0, reset_o}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstErr", {31'b0, err}, 32'd0);
    checkOutput("rstReady", {31'b0, req_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      stuckMask = vecs[i].stuck ? 4'b0100 : 4'b0000;
      applyStimulus(vecs[i].idx, vecs[i].val, vecs[i].expSkip, vecs[i].expErr,
                    vecs[i].expSet, vecs[i].expReset);
      waitIdle();
      checkOutput($sformatf("qAfter%0d", i), {28'b0, qFeedback}, {28'b0, vecs[i].expQ});
      stuckMask = 4'b0000;
    end

    // Reset lands in the second pulse cycle while a new request is already waiting.
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000);
    @(negedge clk); #1;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_idx   = 2'd3;
    req_val   = 1'b0;
    sb.delete();
    nextAcceptEdge = 0;
    @(negedge clk); #1;
    checkOutput("midRstReady", {31'b0, req_ready}, 32'd1);
    checkOutput("midRstSet", {28'b0, set_o}, 32'd0);
    checkOutput("midRstReset", {28'b0, reset_o}, 32'd0);
    checkOutput("midRstDone", {31'b0, done}, 32'd0);
    rst = 1'b0;
    sb.push_back('{cyc + 1, cyc + 1 + P + S, 1'b0, 4'b0000, 4'b1000});
    nextAcceptEdge = cyc + 1 + P + S + 2;
    @(negedge clk); #1;
    checkOutput("postRstAccept", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    waitIdle();
    checkOutput("qAfterRst", {28'b0, qFeedback}, 32'b0010);

    // Back-to-back writes with req_valid kept high between acceptances.
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010);
    applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000);
    waitIdle();
    checkOutput("finalQ", {28'b0, qFeedback}, 32'b1001);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
